// File: rtl/seg_scan.sv
// seg_scan: multiplexed common-anode 7-segment driver.
// Scans DIGITS hex digits of a latched debug value, one digit per rising
// edge of the external 1 kHz scan clock, with a short all-anodes-off gap
// after every digit change to suppress ghosting.
// Optional build macro SEG_LZB_EN: blank leading zero digits (digit 0 is
// always shown).
module seg_scan #(
  parameter int DIGITS    = 4,
  parameter int BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_1K,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    index_reg, index_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [4*DIGITS-1:0] data_lat_reg, data_lat_next;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  logic sync1_reg, sync2_reg, sync3_reg;
  logic tick;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'b1000000;
      4'h1:    hex_decode = 7'b1111001;
      4'h2:    hex_decode = 7'b0100100;
      4'h3:    hex_decode = 7'b0110000;
      4'h4:    hex_decode = 7'b0011001;
      4'h5:    hex_decode = 7'b0010010;
      4'h6:    hex_decode = 7'b0000010;
      4'h7:    hex_decode = 7'b1111000;
      4'h8:    hex_decode = 7'b0000000;
      4'h9:    hex_decode = 7'b0010000;
      4'hA:    hex_decode = 7'b0001000;
      4'hB:    hex_decode = 7'b0000011;
      4'hC:    hex_decode = 7'b1000110;
      4'hD:    hex_decode = 7'b0100001;
      4'hE:    hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  // Two-flop synchroniser plus one delay flop for rising-edge detection of clk_1K.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= clk_1K;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign tick = sync2_reg & ~sync3_reg;

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] lead_zero;
  logic              zero_above;
`endif

  // Next-state logic, then the output pattern that goes with the next state
  // so the output registers update on the same edge as the state.
  always_comb begin
    state_next    = state_reg;
    index_next    = index_reg;
    cnt_next      = cnt_reg;
    data_lat_next = data_lat_reg;

    if (!en) begin
      // Disable wins over a coincident tick; restart waits for a later tick.
      state_next = IDLE;
      index_next = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tick) begin
            data_lat_next = data;
            index_next    = '0;
            cnt_next      = '0;
            state_next    = (BLANK_CYC == 0) ? DRIVE : BLANK;
          end
        end
        BLANK, DRIVE: begin
          if (tick) begin
            if (index_reg == LAST_IDX) begin
              // Latch a new value only at frame wrap so a frame never tears.
              index_next    = '0;
              data_lat_next = data;
            end else begin
              index_next = index_reg + IDX_W'(1);
            end
            cnt_next   = '0;
            state_next = (BLANK_CYC == 0) ? DRIVE : BLANK;
          end else if (state_reg == BLANK) begin
            if (cnt_reg == LAST_CNT) begin
              state_next = DRIVE;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

`ifdef SEG_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above & (data_lat_next[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_above;
    end
`endif

    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state_next == DRIVE) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (index_next == IDX_W'(k)) begin
          an_next[k] = 1'b0;
          seg_next   = hex_decode(data_lat_next[4*k +: 4]);
          dp_next    = ~dp_in[k];
`ifdef SEG_LZB_EN
          if (lead_zero[k]) seg_next = 7'h7F;
`endif
        end
      end
    end
  end

  // State, scan position, latched value and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      index_reg    <= '0;
      cnt_reg      <= '0;
      data_lat_reg <= '0;
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      cnt_reg      <= cnt_next;
      data_lat_reg <= data_lat_next;
      an           <= an_next;
      seg          <= seg_next;
      dp           <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized self-checking bench for seg_scan.
// Two instances share stimulus: a 4-digit display with 4 blanking cycles and
// a 1-digit display with no blanking. A behavioural model tracks the scan in
// terms of "which digit is lit and how long since the last scan tick".
module tb_seg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clk_1K;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp_in;

  logic [3:0]  an0;
  logic [6:0]  seg0;
  logic        dp0;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        dp1;

  seg_scan #(.DIGITS(4), .BLANK_CYC(4)) dut0 (
    .clk(clk), .reset(reset), .clk_1K(clk_1K), .en(en),
    .data(data), .dp_in(dp_in), .an(an0), .seg(seg0), .dp(dp0)
  );

  seg_scan #(.DIGITS(1), .BLANK_CYC(0)) dut1 (
    .clk(clk), .reset(reset), .clk_1K(clk_1K), .en(en),
    .data(data[3:0]), .dp_in(dp_in[0:0]), .an(an1), .seg(seg1), .dp(dp1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  // Segment patterns straight from the hex-decode table.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          nd [2] = '{4, 1};
  int          nb [2] = '{4, 0};
  bit          m_active [2];
  int          m_digit  [2];
  int          m_since  [2];
  logic [15:0] m_frame  [2];
  bit          k_hist   [4];   // clk_1K as seen at the last four clk edges

  // Advance the model by one clk edge using the inputs present at that edge.
  task automatic model_step();
    bit tick;
    for (int h = 3; h > 0; h--) k_hist[h] = k_hist[h-1];
    k_hist[0] = clk_1K;
    if (!reset) begin
      for (int h = 0; h < 4; h++) k_hist[h] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0; m_digit[i] = 0; m_since[i] = 0; m_frame[i] = '0;
      end
      return;
    end
    // A rising edge of clk_1K is acted on two edges after it is first sampled.
    tick = k_hist[2] && !k_hist[3];
    for (int i = 0; i < 2; i++) begin
      if (!en) begin
        m_active[i] = 1'b0;
        m_digit[i]  = 0;
      end else if (tick) begin
        if (!m_active[i] || m_digit[i] == nd[i] - 1) begin
          m_digit[i] = 0;
          m_frame[i] = (i == 0) ? data : {12'h0, data[3:0]};
        end else begin
          m_digit[i]++;
        end
        m_active[i] = 1'b1;
        m_since[i]  = 0;
        if (i == 0) $display("tick cycle=%0d digit=%0d frame=%h", cyc, m_digit[0], m_frame[0]);
      end else if (m_active[i] && m_since[i] < 1000) begin
        m_since[i]++;
      end
    end
  endtask

  task automatic model_expect(input int i, output logic [3:0] e_an,
                              output logic [6:0] e_seg, output logic e_dp);
    logic [15:0] rest;
    e_an  = 4'((1 << nd[i]) - 1);
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (m_active[i] && m_since[i] >= nb[i]) begin
      e_an  = 4'(((1 << nd[i]) - 1) & ~(1 << m_digit[i]));
      rest  = m_frame[i] >> (4 * m_digit[i]);
      e_seg = seg_tab[rest[3:0]];
`ifdef SEG_LZB_EN
      if (m_digit[i] > 0 && rest == 16'h0) e_seg = 7'h7F;
`endif
      e_dp  = ~dp_in[m_digit[i]];
    end
  endtask

  // Stimulus knobs (probabilities are per 1000 cycles).
  bit hold_k  = 1'b0;
  bit rnd_hp  = 1'b0;
  int hp      = 20;
  int ph_cnt  = 0;
  int p_data  = 0;
  int p_en    = 0;
  int p_dp    = 0;
  int p_rst   = 0;

  task automatic run(input int n);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    repeat (n) begin
      @(negedge clk);
      model_step();
      model_expect(0, e_an, e_seg, e_dp);
      check("an0",  {28'h0, an0},  {28'h0, e_an});
      check("seg0", {25'h0, seg0}, {25'h0, e_seg});
      check("dp0",  {31'h0, dp0},  {31'h0, e_dp});
      model_expect(1, e_an, e_seg, e_dp);
      check("an1",  {31'h0, an1},  {31'h0, e_an[0]});
      check("seg1", {25'h0, seg1}, {25'h0, e_seg});
      check("dp1",  {31'h0, dp1},  {31'h0, e_dp});
      cyc++;
      // Drive the inputs for the next rising edge.
      if (hold_k) begin
        clk_1K = 1'b1;
      end else begin
        ph_cnt++;
        if (ph_cnt >= hp) begin
          ph_cnt = 0;
          clk_1K = ~clk_1K;
          if (rnd_hp) hp = $urandom_range(30, 8);
        end
      end
      if ($urandom_range(999) < p_data) data  = 16'($urandom);
      if ($urandom_range(999) < p_dp)   dp_in = 4'($urandom);
      if ($urandom_range(999) < p_en)   en    = ~en;
      if (p_rst > 0) reset = ($urandom_range(999) < p_rst) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    reset  = 1'b0;
    clk_1K = 1'b0;
    en     = 1'b1;
    data   = 16'h12AF;
    dp_in  = 4'b0100;
    for (int h = 0; h < 4; h++) k_hist[h] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_digit[i] = 0; m_since[i] = 0; m_frame[i] = '0;
    end

    // Reset, then a steady 40-cycle scan clock over a couple of frames.
    run(3);
    reset = 1'b1;
    run(400);

    // Mid-frame data change shows up only after the wrap.
    data = 16'h0008;
    run(300);

    // Display disable and later re-enable.
    en = 1'b0;
    run(50);
    en = 1'b1;
    run(200);

    // Reset while the 4-digit display is blanking.
    for (int t = 0; t < 200 && !(m_active[0] && m_since[0] == 1); t++) run(1);
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    run(150);

    // Scan clock stuck high: no ticks, no advance.
    hold_k = 1'b1;
    run(200);
    hold_k = 1'b0;

    // Fully random traffic.
    rnd_hp = 1'b1;
    p_data = 20;
    p_en   = 4;
    p_dp   = 30;
    p_rst  = 2;
    run(6000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Multiplexed 7-segment display driver for the board's 4-digit common-anode display; shows a 16-bit CPU debug value (PC, register or data bus) as hex.
- Runs on the system clock and consumes the 1 kHz scan clock from the clock divider as a data input. That input is synchronised and edge-detected into a one-cycle scan tick; each tick advances one digit.
- Sits between the clock divider and the top-level pin outputs.

Parameters:
- DIGITS, 4, number of digits scanned; legal 1..8; data width = 4*DIGITS.
- BLANK_CYC, 4, clk cycles all anodes are held off after each digit change (anti-ghosting); 0 = no blanking; must be < scan-tick period.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- clk_1K  in  1  scan clock from the divider, async to logic; only rising edges used.
- en  in  1  display enable; 0 = display dark.
- data  in  4*DIGITS  value to display; nibble k shown on digit k (k=0 rightmost).
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- an  out  DIGITS  anode selects, active-low.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point cathode, active-low.

Behaviour:
- Reset (reset=0 at clk edge): an = all 1, seg = 7'h7F, dp = 1, index = 0, blank counter = 0, data_lat = 0, sync flops = 0, state = IDLE.
- Tick generation: s1 <= clk_1K; s2 <= s1; s3 <= s2; tick = s2 & ~s3. One clk pulse per clk_1K rising edge, asserted 2 edges after clk_1K is first sampled high.
- Spurious tick: if clk_1K is high at reset release, one tick fires 2 cycles later; this is accepted behaviour.
- States: IDLE, BLANK, DRIVE.
- IDLE: outputs off. On tick with en=1: data_lat <= data, index <= 0, blank counter <= 0; go to BLANK, or to DRIVE if BLANK_CYC = 0.
- BLANK: an = all 1, seg/dp off. Counter increments each cycle. When counter = BLANK_CYC-1, go to DRIVE.
- DRIVE: an[index] = 0, all other anodes 1; seg = hex_decode(data_lat nibble index); dp = ~dp_in[index].
- On tick in DRIVE or BLANK: if index = DIGITS-1, then index <= 0 and data_lat <= data (frame-synchronous latch, no tearing); else index <= index+1. Then restart BLANK (or go to DRIVE if BLANK_CYC = 0).
- Output latency: outputs are registered and change on the edge after the tick.
- Live data: data changes mid-frame do not appear until the next wrap. dp_in is not latched and is sampled live.
- en: en = 0 in any state forces IDLE, index 0 and outputs off on the next edge; en has priority over tick. Re-enable waits for the next tick.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Index counter width: clog2(DIGITS), minimum 1. DIGITS = 1 never increments; it reloads data_lat on every tick.

Optional Feature:
- SEG_LZB_EN defined: leading-zero blanking computed from data_lat. Digits above the most significant nonzero nibble output seg = 7'h7F while their anode still scans. Digit 0 is always shown, so data_lat = 0 displays a single "0". dp is unaffected.
- SEG_LZB_EN undefined: all digits always show hex, including leading zeros.

Test Plan:
- Reset, then clk_1K period 40 clk, data=16'h12AF, BLANK_CYC=4, en=1 -> after first tick, an=1111 for 4 cycles, then an=1110 with seg=0001110 (F). Next ticks give an=1101 seg=0001000 (A), 1011 seg=0100100 (2), 0111 seg=1111001 (1), then wraps to 1110.
- Change data to 16'h0008 while digit 2 is active -> digits 2 and 3 still show "2","1". After the wrap, digit 0 shows 0000000 (8) and others show 1000000 (0); with SEG_LZB_EN, digits 1..3 show 7'h7F.
- dp_in=4'b0100 -> dp=0 only while an=1011; otherwise dp=1.
- Drop en to 0 while in DRIVE on digit 1 -> next edge gives an=1111, seg=7'h7F, dp=1. Raise en -> dark until next tick, then restarts at digit 0.
- Assert reset mid-BLANK -> all outputs at reset values at the next edge. Holding clk_1K constant high produces no ticks and no scan advance.
- BLANK_CYC=0, DIGITS=1 -> an=0 continuously after the first tick. data_lat is reloaded on every tick, so a data change appears 1 cycle after the next tick.
